// File: rtl/vram_arbiter.sv
// Single-port pixel SRAM arbiter: video scan-out fetches always win, host reads and
// buffered host writes fill the slots the video path leaves idle.
module vram_arbiter #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 8,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_data_valid,
    input  logic              host_wr_valid,
    output logic              host_wr_ready,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    input  logic              host_rd_req,
    input  logic [ADDR_W-1:0] host_rd_addr,
    output logic              host_rd_ack,
    output logic              host_rd_valid,
    output logic [DATA_W-1:0] host_rd_data,
    output logic [4:0]        wfifo_level,
    output logic [15:0]       stall_cnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PTR_W = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
    localparam logic [4:0] LEVEL_FULL = 5'(WFIFO_DEPTH);

    logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [4:0]        level_next;
    logic              fifo_empty;
    logic              rd_busy;
    logic              grant_vid;
    logic              grant_rd;
    logic              grant_wr;
    logic              push;
    logic              pop;
    logic              stall_inc;
    logic              vid_cmd;
    logic [DATA_W-1:0] rd_hold;

    // A read counts as in flight from the slot it is issued until its data returns.
    always_comb begin
        fifo_empty = (wfifo_level == 5'd0);
        rd_busy    = host_rd_ack;
        grant_vid  = vid_req;
        grant_rd   = !vid_req && host_rd_req && fifo_empty && !rd_busy;
        grant_wr   = !vid_req && !fifo_empty;
        push       = host_wr_valid && host_wr_ready;
        pop        = grant_wr;
        stall_inc  = vid_req && (!fifo_empty || host_rd_req) && !rd_busy;
        level_next = wfifo_level;
        if (push && !pop) begin
            level_next = wfifo_level + 5'd1;
        end else if (pop && !push) begin
            level_next = wfifo_level - 5'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr[wr_ptr] <= host_wr_addr;
            fifo_data[wr_ptr] <= host_wr_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            wfifo_level   <= 5'd0;
            host_wr_ready <= 1'b0;
            stall_cnt     <= 16'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            wfifo_level   <= level_next;
            host_wr_ready <= (level_next != LEVEL_FULL);
            if (stall_inc && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    // SRAM command register; address and write data hold when no one wins the slot.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            mem_en         <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            vid_cmd        <= 1'b0;
            host_rd_ack    <= 1'b0;
            vid_data_valid <= 1'b0;
            host_rd_valid  <= 1'b0;
            rd_hold        <= '0;
        end else begin
            mem_en <= grant_vid || grant_rd || grant_wr;
            if (grant_vid) begin
                mem_we   <= 1'b0;
                mem_addr <= vid_addr;
            end else if (grant_rd) begin
                mem_we   <= 1'b0;
                mem_addr <= host_rd_addr;
            end else if (grant_wr) begin
                mem_we    <= 1'b1;
                mem_addr  <= fifo_addr[rd_ptr];
                mem_wdata <= fifo_data[rd_ptr];
            end
            vid_cmd        <= grant_vid;
            host_rd_ack    <= grant_rd;
            vid_data_valid <= vid_cmd;
            host_rd_valid  <= host_rd_ack;
            if (host_rd_valid) begin
                rd_hold <= mem_rdata;
            end
        end
    end

    // Read data arrives straight from the SRAM in the valid cycle; host copy is held after.
    assign vid_data     = vid_data_valid ? mem_rdata : '0;
    assign host_rd_data = host_rd_valid ? mem_rdata : rd_hold;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a synchronous SRAM model preloaded with addr[7:0].
module tb_vram_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        vid_req = 1'b0;
    logic [11:0] vid_addr = '0;
    logic [7:0]  vid_data;
    logic        vid_data_valid;
    logic        host_wr_valid = 1'b0;
    logic        host_wr_ready;
    logic [11:0] host_wr_addr = '0;
    logic [7:0]  host_wr_data = '0;
    logic        host_rd_req = 1'b0;
    logic [11:0] host_rd_addr = '0;
    logic        host_rd_ack;
    logic        host_rd_valid;
    logic [7:0]  host_rd_data;
    logic [4:0]  wfifo_level;
    logic [15:0] stall_cnt;
    logic        mem_en;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    logic [7:0]  sram [4096];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_stall = 16'd0;
    logic [11:0] waddr [5] = '{12'h010, 12'h011, 12'h012, 12'h013, 12'h014};
    logic [7:0]  wdat [5] = '{8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h77};

    vram_arbiter #(.ADDR_W(12), .DATA_W(8), .WFIFO_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_data_valid(vid_data_valid),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
        .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr), .host_rd_ack(host_rd_ack),
        .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data),
        .wfifo_level(wfifo_level), .stall_cnt(stall_cnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        for (int i = 0; i < 4096; i++) sram[i] = i[7:0];
    end

    always @(posedge clk_i) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (host_wr_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_ready got=%b exp=0", host_wr_ready); end
        checks++; if (mem_en !== 1'b0) begin failures++; $display("[TB] FAIL rst_mem_en got=%b exp=0", mem_en); end
        checks++; if (stall_cnt !== 16'd0) begin failures++; $display("[TB] FAIL rst_stall got=%h exp=0", stall_cnt); end
        #10 rst_n = 1'b1;
        tick();
        checks++; if (host_wr_ready !== 1'b1) begin failures++; $display("[TB] FAIL rel_ready got=%b exp=1", host_wr_ready); end
        checks++; if (wfifo_level !== 5'd0) begin failures++; $display("[TB] FAIL rel_level got=%0d exp=0", wfifo_level); end
        checks++; if (vid_data_valid !== 1'b0 || host_rd_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL rel_valid got=%b%b exp=00", vid_data_valid, host_rd_valid);
        end
    endtask

    task automatic test_video_stream();
        logic [7:0] exp_d;
        for (int k = 0; k < 756; k++) begin
            checks++;
            if (vid_data_valid !== (k >= 2 && k <= 753)) begin
                failures++; $display("[TB] FAIL vid_valid cyc=%0d got=%b", k, vid_data_valid);
            end
            if (k >= 2 && k <= 753) begin
                exp_d = 8'(k - 2);
                checks++;
                if (vid_data !== exp_d) begin
                    failures++; $display("[TB] FAIL vid_data cyc=%0d got=%h exp=%h", k, vid_data, exp_d);
                end
            end
            vid_req  = (k < 752);
            vid_addr = 12'(k);
            tick();
        end
    endtask

    task automatic test_write_fill();
        int exp_level = 0;
        int idx = 0;
        for (int c = 0; c < 8; c++) begin
            checks++; if (wfifo_level !== 5'(exp_level)) begin failures++; $display("[TB] FAIL fill_level cyc=%0d got=%0d exp=%0d", c, wfifo_level, exp_level); end
            checks++; if (host_wr_ready !== (exp_level != 4)) begin failures++; $display("[TB] FAIL fill_ready cyc=%0d got=%b", c, host_wr_ready); end
            checks++; if (stall_cnt !== exp_stall) begin failures++; $display("[TB] FAIL fill_stall cyc=%0d got=%0d exp=%0d", c, stall_cnt, exp_stall); end
            checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL fill_we cyc=%0d got=%b exp=0", c, mem_we); end
            vid_req       = 1'b1;
            vid_addr      = 12'(c);
            host_wr_valid = (idx < 5);
            host_wr_addr  = waddr[idx < 5 ? idx : 4];
            host_wr_data  = wdat[idx < 5 ? idx : 4];
            if (exp_level != 0) exp_stall++;
            if (host_wr_valid && exp_level < 4) begin
                exp_level++;
                idx++;
            end
            tick();
        end
        checks++; if (wfifo_level !== 5'd4 || host_wr_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL fill_full got_level=%0d got_ready=%b exp=4/0", wfifo_level, host_wr_ready);
        end
    endtask

    task automatic test_drain_read();
        vid_req       = 1'b0;
        host_wr_valid = 1'b0;
        host_rd_req   = 1'b1;
        host_rd_addr  = 12'h010;
        tick();
        for (int d = 1; d <= 7; d++) begin
            if (d <= 4) begin
                checks++;
                if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== waddr[d-1] || mem_wdata !== wdat[d-1]) begin
                    failures++; $display("[TB] FAIL drain_wr d=%0d got en=%b we=%b a=%h w=%h exp a=%h w=%h",
                                         d, mem_en, mem_we, mem_addr, mem_wdata, waddr[d-1], wdat[d-1]);
                end
                checks++; if (wfifo_level !== 5'(4 - d)) begin failures++; $display("[TB] FAIL drain_level d=%0d got=%0d exp=%0d", d, wfifo_level, 4 - d); end
            end
            checks++; if (host_rd_ack !== (d == 5)) begin failures++; $display("[TB] FAIL drain_ack d=%0d got=%b", d, host_rd_ack); end
            checks++; if (host_rd_valid !== (d == 6)) begin failures++; $display("[TB] FAIL drain_rvalid d=%0d got=%b", d, host_rd_valid); end
            if (d == 5) begin
                checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h010) begin
                    failures++; $display("[TB] FAIL drain_rdcmd got en=%b we=%b a=%h exp 1/0/010", mem_en, mem_we, mem_addr);
                end
            end
            if (d >= 6) begin
                checks++; if (host_rd_data !== 8'hA5) begin failures++; $display("[TB] FAIL drain_rdata d=%0d got=%h exp=a5", d, host_rd_data); end
            end
            if (host_rd_ack) host_rd_req = 1'b0;
            tick();
        end
        checks++; if (stall_cnt !== exp_stall) begin failures++; $display("[TB] FAIL drain_stall got=%0d exp=%0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_video_priority();
        host_rd_req  = 1'b1;
        host_rd_addr = 12'h011;
        for (int a = 0; a < 7; a++) begin
            checks++; if (host_rd_ack !== (a == 4)) begin failures++; $display("[TB] FAIL prio_ack a=%0d got=%b", a, host_rd_ack); end
            checks++; if (vid_data_valid !== (a >= 2 && a <= 4)) begin failures++; $display("[TB] FAIL prio_vvalid a=%0d got=%b", a, vid_data_valid); end
            if (a >= 2 && a <= 4) begin
                checks++; if (vid_data !== 8'(8'h20 + a - 2)) begin failures++; $display("[TB] FAIL prio_vdata a=%0d got=%h exp=%h", a, vid_data, 8'(8'h20 + a - 2)); end
            end
            if (a == 5) begin
                checks++; if (host_rd_valid !== 1'b1 || host_rd_data !== 8'h5A) begin
                    failures++; $display("[TB] FAIL prio_rdata got v=%b d=%h exp 1/5a", host_rd_valid, host_rd_data);
                end
            end
            if (host_rd_ack) host_rd_req = 1'b0;
            vid_req  = (a < 3);
            vid_addr = 12'(12'h020 + a);
            tick();
        end
        exp_stall = exp_stall + 16'd3;
        checks++; if (stall_cnt !== exp_stall) begin failures++; $display("[TB] FAIL prio_stall got=%0d exp=%0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_stall_saturate();
        vid_req      = 1'b1;
        vid_addr     = 12'h000;
        host_rd_req  = 1'b1;
        host_rd_addr = 12'h011;
        force dut.stall_cnt = 16'hFFFE;
        tick();
        release dut.stall_cnt;
        checks++; if (stall_cnt !== 16'hFFFE) begin failures++; $display("[TB] FAIL sat_preload got=%h exp=fffe", stall_cnt); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("[TB] FAIL sat_hold i=%0d got=%h exp=ffff", i, stall_cnt); end
        end
        vid_req = 1'b0;
        tick();
        checks++; if (host_rd_ack !== 1'b1) begin failures++; $display("[TB] FAIL sat_ack got=%b exp=1", host_rd_ack); end
        host_rd_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        vid_req       = 1'b1;
        vid_addr      = 12'h030;
        host_wr_valid = 1'b1;
        host_wr_addr  = 12'h040;
        host_wr_data  = 8'h99;
        tick();
        host_wr_valid = 1'b0;
        vid_addr      = 12'h031;
        tick();
        tick();
        #3 rst_n = 1'b0;
        vid_req = 1'b0;
        #1;
        checks++; if (vid_data_valid !== 1'b0 || vid_data !== 8'h00) begin failures++; $display("[TB] FAIL mid_vid got v=%b d=%h exp 0/00", vid_data_valid, vid_data); end
        checks++; if (host_rd_data !== 8'h00 || host_rd_valid !== 1'b0 || host_rd_ack !== 1'b0) begin
            failures++; $display("[TB] FAIL mid_host got d=%h v=%b ack=%b exp 00/0/0", host_rd_data, host_rd_valid, host_rd_ack);
        end
        checks++; if (wfifo_level !== 5'd0 || host_wr_ready !== 1'b0 || stall_cnt !== 16'd0) begin
            failures++; $display("[TB] FAIL mid_fifo got lvl=%0d rdy=%b stall=%h exp 0/0/0", wfifo_level, host_wr_ready, stall_cnt);
        end
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 12'h000 || mem_wdata !== 8'h00) begin
            failures++; $display("[TB] FAIL mid_mem got en=%b we=%b a=%h w=%h exp zeros", mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk_i);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (vid_data_valid !== 1'b0 || host_rd_valid !== 1'b0) begin
                failures++; $display("[TB] FAIL mid_post i=%0d got v=%b rv=%b exp 0/0", i, vid_data_valid, host_rd_valid);
            end
        end
        checks++; if (host_wr_ready !== 1'b1 || wfifo_level !== 5'd0) begin
            failures++; $display("[TB] FAIL mid_post_fifo got rdy=%b lvl=%0d exp 1/0", host_wr_ready, wfifo_level);
        end
    endtask

    initial begin
        test_reset();
        test_video_stream();
        test_write_fill();
        test_drain_read();
        test_video_priority();
        test_stall_saturate();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
